vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates 640x480 @ ~60 Hz VGA raster timing from the 50 MHz system clock.
- Uses an internal divide-by-2 pixel clock-enable instead of a derived clock.
- Produces the h/v sync, composite sync, blank and pixel coordinates consumed by videoGen.
- Sits directly upstream of the pixel colour generator and the video DAC.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  in  1  50 MHz system clock; the only clock
- rst  in  1  synchronous, active-high reset
- pix_ce  out  1  pixel clock-enable, high every 2nd clk
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- sync_b  out  1  composite sync to DAC, hsync AND vsync
- blank_b  out  1  high only inside the visible region
- x  out  10  horizontal counter, 0..H_TOTAL-1
- y  out  10  vertical counter, 0..V_TOTAL-1
- line_start  out  1  high for the pixel slot where x==0
- frame_start  out  1  high for the pixel slot where x==0 and y==0

Behaviour:
- Reset and clocking:
  - One clock (clk). Reset is synchronous and active-high on rst.
  - All outputs are registered.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset values:
  - h_cnt = v_cnt = 0, pix_ce = 0.
  - hsync = vsync = sync_b = 1.
  - blank_b = 0, x = y = 0, line_start = frame_start = 0.
- pix_ce:
  - Toggles every clk.
  - First clk edge after rst deasserts drives it to 1, so it is high on alternate cycles: 25 MHz effective pixel rate.
- Counter update (only at clk edges where pix_ce==1):
  - If h_cnt == H_TOTAL-1: h_cnt <= 0, and v_cnt <= (v_cnt == V_TOTAL-1) ? 0 : v_cnt+1.
  - Otherwise h_cnt <= h_cnt+1 and v_cnt holds.
- Output register (same pix_ce edge), decoded from the pre-increment h_cnt/v_cnt:
  - x <= h_cnt, y <= v_cnt.
  - hsync <= ~(h_cnt >= H_ACTIVE+H_FP && h_cnt < H_ACTIVE+H_FP+H_SYNC), i.e. low for 656..751.
  - vsync <= ~(v_cnt >= V_ACTIVE+V_FP && v_cnt < V_ACTIVE+V_FP+V_SYNC), i.e. low for lines 490..491.
  - blank_b <= (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - sync_b <= hsync_next & vsync_next.
  - line_start <= (h_cnt == 0); frame_start <= (h_cnt == 0 && v_cnt == 0).
- Output timing:
  - Outputs lag the counters by one pixel slot and are stable for 2 clk between pix_ce pulses.
  - A consumer sampling on pix_ce sees each pixel exactly once.
- Wrap-around: h and v wrap in the same slot at (799,524) -> (0,0); no gap or extra slot.
- Reset mid-frame: on the next clk all state returns to reset values; the raster restarts at (0,0). The first frame_start appears in the first output slot after reset, with no partial frame flag.
- Arithmetic: counters are 10 bits unsigned. Comparisons are unsigned, and parameters must satisfy H_TOTAL, V_TOTAL <= 1024.

Optional Feature:
- Macro: VGA_TIMING_PIPE_EN.
- When defined:
  - hsync, vsync, sync_b, blank_b, line_start and frame_start pass through one extra pix_ce-qualified register stage. They lag x/y by exactly one pixel slot, to match a downstream colour generator with a registered colour output.
  - Extra stage reset values equal the output reset values above.
- When undefined: all outputs are aligned in the same slot as described in Behaviour.

Test Plan:
- Reset: hold rst 3 clk -> pix_ce=0, hsync=vsync=sync_b=1, blank_b=0, x=y=0. After release, pix_ce pattern is 1,0,1,0…
- Horizontal: line 0 -> hsync low exactly when x=656..751 (96 slots = 192 clk); blank_b high exactly for x=0..639; line_start period = 1600 clk.
- Vertical: full frame -> vsync low exactly for y=490..491 (1600 pix_ce slots); blank_b low for all x when y>=480; y reaches 524 then 0.
- Frame period: consecutive frame_start rising edges 840000 clk apart; x/y wrap (799,524)->(0,0) in one slot; sync_b == hsync&vsync every cycle.
- Mid-frame reset: assert rst at x=300, y=200 -> next clk all reset values; first output slot after release shows x=0, y=0, frame_start=1.
- VGA_TIMING_PIPE_EN build: hsync falls in the slot where x=657 (not 656); blank_b falls where x=641; x/y sequence is unchanged versus the default build.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480 VGA raster timing from a 50 MHz clock using a divide-by-2 pixel clock-enable.
// Define VGA_TIMING_PIPE_EN to delay the sync/blank/start flags one extra pixel slot behind x/y.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_ce,
    output logic       hsync,
    output logic       vsync,
    output logic       sync_b,
    output logic       blank_b,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       hs_next;
    logic       vs_next;
    logic       blank_next;
    logic       ls_next;
    logic       fs_next;

    // Flags decoded from the counters before they advance, so they describe the slot x/y will show.
    always_comb begin
        hs_next    = ~((h_cnt >= HS_START) && (h_cnt < HS_END));
        vs_next    = ~((v_cnt >= VS_START) && (v_cnt < VS_END));
        blank_next = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        ls_next    = (h_cnt == 10'd0);
        fs_next    = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_ce <= 1'b0;
            h_cnt  <= 10'd0;
            v_cnt  <= 10'd0;
            x      <= 10'd0;
            y      <= 10'd0;
        end else begin
            pix_ce <= ~pix_ce;
            if (pix_ce) begin
                x <= h_cnt;
                y <= v_cnt;
                if (h_cnt == H_LAST) begin
                    h_cnt <= 10'd0;
                    v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
            end
        end
    end

`ifdef VGA_TIMING_PIPE_EN
    logic hs_d;
    logic vs_d;
    logic sync_d;
    logic blank_d;
    logic ls_d;
    logic fs_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_d        <= 1'b1;
            vs_d        <= 1'b1;
            sync_d      <= 1'b1;
            blank_d     <= 1'b0;
            ls_d        <= 1'b0;
            fs_d        <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            sync_b      <= 1'b1;
            blank_b     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_ce) begin
            hs_d        <= hs_next;
            vs_d        <= vs_next;
            sync_d      <= hs_next & vs_next;
            blank_d     <= blank_next;
            ls_d        <= ls_next;
            fs_d        <= fs_next;
            hsync       <= hs_d;
            vsync       <= vs_d;
            sync_b      <= sync_d;
            blank_b     <= blank_d;
            line_start  <= ls_d;
            frame_start <= fs_d;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            sync_b      <= 1'b1;
            blank_b     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_ce) begin
            hsync       <= hs_next;
            vsync       <= vs_next;
            sync_b      <= hs_next & vs_next;
            blank_b     <= blank_next;
            line_start  <= ls_next;
            frame_start <= fs_next;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full 800-pixel lines with a shortened 10-line frame.
// Flag expectations come from an independent per-slot raster model (one slot later with VGA_TIMING_PIPE_EN).
module tb_vga_timing_gen;

    localparam int VA = 4, VF = 2, VS = 2, VB = 2;
    localparam int V_TOT = VA + VF + VS + VB;
`ifdef VGA_TIMING_PIPE_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_ce, hsync, vsync, sync_b, blank_b, line_start, frame_start;
    logic [9:0] x, y;

    vga_timing_gen #(.V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .hsync(hsync), .vsync(vsync),
        .sync_b(sync_b), .blank_b(blank_b), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0, n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Raster model: mx/my is the slot expected next; p_* hold the previous slot's decode.
    int mx, my, lx, ly, wraps;
    logic p_hs, p_vs, p_bl, p_ls, p_fs;
    // Line-0 / frame-0 statistics gathered from observed outputs.
    int hs_low, bl_high, vs_low, hs_fall_x, bl_fall_x, ls_n, fs_n, wrap_seen;
    int ls_cyc[2], fs_cyc[2];
    logic o_hs, o_bl;

    task automatic model_reset();
        mx = 0; my = 0; lx = -1; ly = -1;
        p_hs = 1'b1; p_vs = 1'b1; p_bl = 1'b0; p_ls = 1'b0; p_fs = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_pix_ce"}, pix_ce, 0);
        chk({tag, "_hsync"}, hsync, 1);
        chk({tag, "_vsync"}, vsync, 1);
        chk({tag, "_sync_b"}, sync_b, 1);
        chk({tag, "_blank_b"}, blank_b, 0);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_line_start"}, line_start, 0);
        chk({tag, "_frame_start"}, frame_start, 0);
    endtask

    task automatic check_slot();
        logic d_hs, d_vs, d_bl, d_ls, d_fs, e_hs, e_vs, e_bl, e_ls, e_fs;
        d_hs = !(mx >= 656 && mx < 752);
        d_vs = !(my >= VA + VF && my < VA + VF + VS);
        d_bl = (mx < 640) && (my < VA);
        d_ls = (mx == 0);
        d_fs = (mx == 0) && (my == 0);
        if (LAG == 1) begin
            e_hs = p_hs; e_vs = p_vs; e_bl = p_bl; e_ls = p_ls; e_fs = p_fs;
        end else begin
            e_hs = d_hs; e_vs = d_vs; e_bl = d_bl; e_ls = d_ls; e_fs = d_fs;
        end
        chk("slot_pix_ce", pix_ce, 0);
        chk("x", x, mx);
        chk("y", y, my);
        chk("hsync", hsync, e_hs);
        chk("vsync", vsync, e_vs);
        chk("sync_b", sync_b, e_hs & e_vs);
        chk("blank_b", blank_b, e_bl);
        chk("line_start", line_start, e_ls);
        chk("frame_start", frame_start, e_fs);
        if (lx == 799 && ly == V_TOT - 1) begin
            chk("wrap_xy", {x, y}, 20'd0);
            wrap_seen++;
        end
        // Statistics from observed outputs.
        if (wraps == 0 && my == 0) begin
            if (!hsync) hs_low++;
            if (blank_b) bl_high++;
            if (o_hs && !hsync && hs_fall_x < 0) hs_fall_x = x;
            if (o_bl && !blank_b && bl_fall_x < 0) bl_fall_x = x;
        end
        if (wraps == 0 && !vsync) vs_low++;
        if (line_start && ls_n < 2) begin ls_cyc[ls_n] = cyc; ls_n++; end
        if (frame_start && fs_n < 2) begin fs_cyc[fs_n] = cyc; fs_n++; end
        o_hs = hsync; o_bl = blank_b;
        p_hs = d_hs; p_vs = d_vs; p_bl = d_bl; p_ls = d_ls; p_fs = d_fs;
        lx = mx; ly = my;
        if (mx == 799) begin
            mx = 0;
            if (my == V_TOT - 1) begin my = 0; wraps++; end
            else my = my + 1;
        end else begin
            mx = mx + 1;
        end
    endtask

    task automatic step_slot();
        @(negedge clk);
        chk("mid_pix_ce", pix_ce, 1);
        chk("cb_sync_b", sync_b, hsync & vsync);
        @(negedge clk);
        check_slot();
    endtask

    // Release reset at a negedge; the next edge raises pix_ce, the one after produces slot (0,0).
    task automatic startup(input string tag);
        rst = 1'b0;
        @(negedge clk);
        chk({tag, "_first_pix_ce"}, pix_ce, 1);
        chk({tag, "_pre_x"}, x, 0);
        chk({tag, "_pre_frame_start"}, frame_start, 0);
        model_reset();
        @(negedge clk);
        chk({tag, "_slot0_x"}, x, 0);
        chk({tag, "_slot0_y"}, y, 0);
        chk({tag, "_slot0_frame_start"}, frame_start, (LAG == 0) ? 1 : 0);
        check_slot();
    endtask

    initial begin
        wraps = 0; hs_low = 0; bl_high = 0; vs_low = 0; hs_fall_x = -1; bl_fall_x = -1;
        ls_n = 0; fs_n = 0; wrap_seen = 0; o_hs = 1'b1; o_bl = 1'b0;
        model_reset();

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");

        startup("start");
        for (int s = 0; s < 800 * V_TOT; s++) step_slot();

        chk("line0_hsync_low_slots", hs_low, 96);
        chk("line0_blank_high_slots", bl_high, 640);
        chk("hsync_fall_x", hs_fall_x, 656 + LAG);
        chk("blank_fall_x", bl_fall_x, 640 + LAG);
        chk("frame0_vsync_low_slots", vs_low, 1600);
        chk("line_start_period", ls_cyc[1] - ls_cyc[0], 1600);
        chk("frame_start_period", fs_cyc[1] - fs_cyc[0], 1600 * V_TOT);
        chk("wrap_count", wrap_seen, 1);

        // Advance to (300,5), then reset mid-frame.
        for (int s = 0; s < 800 * V_TOT && !(lx == 300 && ly == 5); s++) step_slot();
        chk("reached_300_5", {22'd0, lx[9:0]} + (ly << 10), 300 + (5 << 10));
        rst = 1'b1;
        @(negedge clk);
        check_reset("midreset");
        startup("restart");
        for (int s = 0; s < 4; s++) step_slot();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
